// File: rtl/decoder_stage_controller.sv
// Stage sequencer for a PE-array decoder: walks each syndrome round through
// load / grow / merge / peel / result / write-back and broadcasts the stage.
module decoder_stage_controller #(
  parameter  int NUM_PES      = 16,
  parameter  int NUM_CONTEXTS = 2,
  parameter  int GROW_CYCLES  = 2,
  parameter  int MERGE_QUIET  = 3,
  parameter  int PEEL_CYCLES  = 2,
  parameter  int MAX_ITER     = 15,
  localparam int STAGE_WIDTH  = 3,
  localparam int ITER_W       = $clog2(MAX_ITER + 1),
  localparam int CTX_W        = (NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   input_valid,
  output logic                   input_ready,
  input  logic [NUM_PES-1:0]     busy,
  input  logic [NUM_PES-1:0]     odd,
  output logic [STAGE_WIDTH-1:0] global_stage,
  output logic                   output_valid,
  input  logic                   output_ready,
  output logic [ITER_W-1:0]      iteration_count,
  output logic                   iter_limit_hit,
  output logic [CTX_W-1:0]       context_id
);

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd4;
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = 3'd5;
  localparam logic [STAGE_WIDTH-1:0] STAGE_WRITE_TO_MEM        = 3'd6;

  // One shared phase counter: GROW/PEELING cycle count, or the MERGE quiet count.
  localparam int CNT_MAX = (GROW_CYCLES > MERGE_QUIET)
                         ? ((GROW_CYCLES > PEEL_CYCLES) ? GROW_CYCLES : PEEL_CYCLES)
                         : ((MERGE_QUIET > PEEL_CYCLES) ? MERGE_QUIET : PEEL_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [STAGE_WIDTH-1:0] state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ITER_W-1:0]      iter_q, iter_d;
  logic                   limit_q, limit_d;
  logic [CTX_W-1:0]       ctx_q, ctx_d;

  logic             any_busy, any_odd, iter_at_max, merge_done;
  logic [CNT_W-1:0] quiet_next;

  assign any_busy    = |busy;
  assign any_odd     = |odd;
  assign iter_at_max = (iter_q == ITER_W'(MAX_ITER));
  assign quiet_next  = any_busy ? '0 : cnt_q + 1'b1;
  assign merge_done  = (quiet_next == CNT_W'(MERGE_QUIET));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= STAGE_IDLE;
      cnt_q   <= '0;
      iter_q  <= '0;
      limit_q <= 1'b0;
      ctx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iter_q  <= iter_d;
      limit_q <= limit_d;
      ctx_q   <= ctx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      STAGE_IDLE:                if (input_valid) state_d = STAGE_MEASUREMENT_LOADING;
      STAGE_MEASUREMENT_LOADING: state_d = STAGE_GROW;
      STAGE_GROW:                if (cnt_q == CNT_W'(GROW_CYCLES - 1)) state_d = STAGE_MERGE;
      STAGE_MERGE: begin
        if (merge_done) state_d = (any_odd && !iter_at_max) ? STAGE_GROW : STAGE_PEELING;
      end
      STAGE_PEELING:             if (cnt_q == CNT_W'(PEEL_CYCLES - 1)) state_d = STAGE_RESULT_VALID;
      STAGE_RESULT_VALID:        if (output_ready) state_d = STAGE_WRITE_TO_MEM;
      STAGE_WRITE_TO_MEM:        state_d = STAGE_IDLE;
      default:                   state_d = STAGE_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = '0;
    iter_d  = iter_q;
    limit_d = limit_q;
    ctx_d   = ctx_q;
    // The counter restarts from zero on every stage change.
    if (state_d == state_q) begin
      case (state_q)
        STAGE_GROW, STAGE_PEELING: cnt_d = cnt_q + 1'b1;
        STAGE_MERGE:               cnt_d = quiet_next;
        default:                   cnt_d = '0;
      endcase
    end
    case (state_q)
      STAGE_MEASUREMENT_LOADING: begin
        iter_d  = '0;
        limit_d = 1'b0;
      end
      STAGE_MERGE: begin
        if (merge_done && any_odd) begin
          if (iter_at_max) limit_d = 1'b1;
          else             iter_d  = iter_q + 1'b1;
        end
      end
      STAGE_WRITE_TO_MEM: begin
        ctx_d = (ctx_q == CTX_W'(NUM_CONTEXTS - 1)) ? '0 : ctx_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    global_stage    = state_q;
    input_ready     = (state_q == STAGE_IDLE) && !reset;
    output_valid    = (state_q == STAGE_RESULT_VALID);
    iteration_count = iter_q;
    iter_limit_hit  = limit_q;
    context_id      = ctx_q;
  end

endmodule

// File: tb/tb_decoder_stage_controller.sv
// Self-checking bench: stage run-lengths are predicted into a scoreboard queue
// and compared against the observed stage sequence of each decode.
module tb_decoder_stage_controller;

  localparam int NUM_PES = 16, NUM_CONTEXTS = 2, GROW_CYCLES = 2;
  localparam int MERGE_QUIET = 3, PEEL_CYCLES = 2, MAX_ITER = 15;
  localparam int S_IDLE = 0, S_LOAD = 1, S_GROW = 2, S_MERGE = 3;
  localparam int S_PEEL = 4, S_RV = 5, S_WR = 6;

  logic clk = 1'b0;
  logic reset, input_valid, input_ready, output_valid, output_ready, iter_limit_hit;
  logic [NUM_PES-1:0] busy, odd;
  logic [2:0] global_stage;
  logic [3:0] iteration_count;
  logic [0:0] context_id;

  decoder_stage_controller #(
    .NUM_PES(NUM_PES), .NUM_CONTEXTS(NUM_CONTEXTS), .GROW_CYCLES(GROW_CYCLES),
    .MERGE_QUIET(MERGE_QUIET), .PEEL_CYCLES(PEEL_CYCLES), .MAX_ITER(MAX_ITER)
  ) dut (
    .clk(clk), .reset(reset), .input_valid(input_valid), .input_ready(input_ready),
    .busy(busy), .odd(odd), .global_stage(global_stage), .output_valid(output_valid),
    .output_ready(output_ready), .iteration_count(iteration_count),
    .iter_limit_hit(iter_limit_hit), .context_id(context_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int exp_st[$], exp_len[$], obs_st[$], obs_len[$];
  int ov_cycles, ir_bad, exp_ctx;
  bit timed_out;

  task automatic push_exp(input int st, input int len);
    exp_st.push_back(st);
    exp_len.push_back(len);
  endtask

  // Expected stage runs of one decode with `rounds` extra growth iterations.
  task automatic push_decode(input int rounds, input int merge0_len, input int rv_len);
    push_exp(S_LOAD, 1);
    for (int r = 0; r <= rounds; r++) begin
      push_exp(S_GROW, GROW_CYCLES);
      push_exp(S_MERGE, (r == 0) ? merge0_len : MERGE_QUIET);
    end
    push_exp(S_PEEL, PEEL_CYCLES);
    push_exp(S_RV, rv_len);
    push_exp(S_WR, 1);
  endtask

  // Drives one decode, responding to the broadcast stage, and records stage runs.
  task automatic run_decode(input int odd_rounds, input int glitch_cyc,
                            input int ready_delay, input bit hold_valid);
    int st, prev, run, merge_idx, cyc;
    bit done;
    obs_st.delete(); obs_len.delete();
    ov_cycles = 0; ir_bad = 0; timed_out = 0;
    prev = -1; run = 0; merge_idx = 0; cyc = 0; done = 0;
    @(negedge clk);
    input_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      cyc++;
      st = int'(global_stage);
      if (st != prev) begin
        if (prev >= 0) begin
          obs_st.push_back(prev);
          obs_len.push_back(run);
        end
        if (prev == S_MERGE) merge_idx++;
        run = 0;
      end
      run++;
      prev = st;
      if (input_ready !== (st == S_IDLE)) ir_bad++;
      if (output_valid === 1'b1) ov_cycles++;
      input_valid = hold_valid && (st != S_WR) && (st != S_IDLE);
      if (st == S_MERGE) begin
        busy = (glitch_cyc > 0 && merge_idx == 0 && run == glitch_cyc) ? 16'h0020 : '0;
        odd  = (merge_idx < odd_rounds) ? 16'h0100 : '0;
      end else begin
        busy = NUM_PES'($urandom);
        odd  = NUM_PES'($urandom);
      end
      output_ready = (st == S_RV) ? (run > ready_delay) : 1'($urandom_range(0, 1));
      if (st == S_IDLE) done = 1;
      if (cyc > 400) begin
        timed_out = 1;
        done = 1;
      end
    end
    input_valid = 0; busy = '0; odd = '0; output_ready = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (int'(global_stage) !== S_IDLE) begin n_fail++; $display("FAIL reset_stage: got %0d expected %0d", global_stage, S_IDLE); end
    n_checks++; if (input_ready !== 1'b0) begin n_fail++; $display("FAIL reset_input_ready: got %b expected 0", input_ready); end
    n_checks++; if (output_valid !== 1'b0) begin n_fail++; $display("FAIL reset_output_valid: got %b expected 0", output_valid); end
    n_checks++; if (iteration_count !== 4'd0 || iter_limit_hit !== 1'b0) begin n_fail++; $display("FAIL reset_iter: got %0d/%b expected 0/0", iteration_count, iter_limit_hit); end
    n_checks++; if (context_id !== 1'b0) begin n_fail++; $display("FAIL reset_ctx: got %0d expected 0", context_id); end
    reset = 0;
    #1;
    n_checks++; if (input_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", input_ready); end
    exp_ctx = 0;
  endtask

  task automatic test_no_odd();
    int es, el, os, ol;
    push_decode(0, MERGE_QUIET, 1);
    run_decode(0, 0, 0, 1);
    exp_ctx = (exp_ctx + 1) % NUM_CONTEXTS;
    n_checks++; if (timed_out || obs_st.size() != exp_st.size()) begin n_fail++; $display("FAIL no_odd_runs: got %0d runs (timeout %0b) expected %0d", obs_st.size(), timed_out, exp_st.size()); end
    while (exp_st.size() > 0) begin
      es = exp_st.pop_front(); el = exp_len.pop_front(); os = -1; ol = -1;
      if (obs_st.size() > 0) begin os = obs_st.pop_front(); ol = obs_len.pop_front(); end
      n_checks++; if (os !== es || ol !== el) begin n_fail++; $display("FAIL no_odd_run: got stage %0d x%0d expected stage %0d x%0d", os, ol, es, el); end
    end
    n_checks++; if (ir_bad !== 0) begin n_fail++; $display("FAIL no_odd_input_ready: got %0d bad cycles expected 0", ir_bad); end
    n_checks++; if (iteration_count !== 4'd0 || iter_limit_hit !== 1'b0) begin n_fail++; $display("FAIL no_odd_iter: got %0d/%b expected 0/0", iteration_count, iter_limit_hit); end
    n_checks++; if (int'(context_id) !== exp_ctx) begin n_fail++; $display("FAIL no_odd_ctx: got %0d expected %0d", context_id, exp_ctx); end
    @(negedge clk);
    n_checks++; if (int'(global_stage) !== S_IDLE) begin n_fail++; $display("FAIL no_odd_not_queued: got %0d expected %0d", global_stage, S_IDLE); end
  endtask

  task automatic test_two_rounds();
    int es, el, os, ol;
    push_decode(2, MERGE_QUIET, 1);
    run_decode(2, 0, 0, 0);
    exp_ctx = (exp_ctx + 1) % NUM_CONTEXTS;
    n_checks++; if (timed_out || obs_st.size() != exp_st.size()) begin n_fail++; $display("FAIL two_rounds_runs: got %0d runs (timeout %0b) expected %0d", obs_st.size(), timed_out, exp_st.size()); end
    while (exp_st.size() > 0) begin
      es = exp_st.pop_front(); el = exp_len.pop_front(); os = -1; ol = -1;
      if (obs_st.size() > 0) begin os = obs_st.pop_front(); ol = obs_len.pop_front(); end
      n_checks++; if (os !== es || ol !== el) begin n_fail++; $display("FAIL two_rounds_run: got stage %0d x%0d expected stage %0d x%0d", os, ol, es, el); end
    end
    n_checks++; if (iteration_count !== 4'd2 || iter_limit_hit !== 1'b0) begin n_fail++; $display("FAIL two_rounds_iter: got %0d/%b expected 2/0", iteration_count, iter_limit_hit); end
    n_checks++; if (int'(context_id) !== exp_ctx) begin n_fail++; $display("FAIL two_rounds_ctx: got %0d expected %0d", context_id, exp_ctx); end
  endtask

  task automatic test_busy_glitch();
    int es, el, os, ol;
    push_decode(0, MERGE_QUIET + 3, 1);
    run_decode(0, 3, 0, 0);
    exp_ctx = (exp_ctx + 1) % NUM_CONTEXTS;
    n_checks++; if (timed_out || obs_st.size() != exp_st.size()) begin n_fail++; $display("FAIL glitch_runs: got %0d runs (timeout %0b) expected %0d", obs_st.size(), timed_out, exp_st.size()); end
    while (exp_st.size() > 0) begin
      es = exp_st.pop_front(); el = exp_len.pop_front(); os = -1; ol = -1;
      if (obs_st.size() > 0) begin os = obs_st.pop_front(); ol = obs_len.pop_front(); end
      n_checks++; if (os !== es || ol !== el) begin n_fail++; $display("FAIL glitch_run: got stage %0d x%0d expected stage %0d x%0d", os, ol, es, el); end
    end
    n_checks++; if (int'(context_id) !== exp_ctx) begin n_fail++; $display("FAIL glitch_ctx: got %0d expected %0d", context_id, exp_ctx); end
  endtask

  task automatic test_iter_cap();
    int es, el, os, ol;
    push_decode(MAX_ITER, MERGE_QUIET, 1);
    run_decode(99, 0, 0, 0);
    exp_ctx = (exp_ctx + 1) % NUM_CONTEXTS;
    n_checks++; if (timed_out || obs_st.size() != exp_st.size()) begin n_fail++; $display("FAIL cap_runs: got %0d runs (timeout %0b) expected %0d", obs_st.size(), timed_out, exp_st.size()); end
    while (exp_st.size() > 0) begin
      es = exp_st.pop_front(); el = exp_len.pop_front(); os = -1; ol = -1;
      if (obs_st.size() > 0) begin os = obs_st.pop_front(); ol = obs_len.pop_front(); end
      n_checks++; if (os !== es || ol !== el) begin n_fail++; $display("FAIL cap_run: got stage %0d x%0d expected stage %0d x%0d", os, ol, es, el); end
    end
    n_checks++; if (int'(iteration_count) !== MAX_ITER || iter_limit_hit !== 1'b1) begin n_fail++; $display("FAIL cap_iter: got %0d/%b expected %0d/1", iteration_count, iter_limit_hit, MAX_ITER); end
    n_checks++; if (int'(context_id) !== exp_ctx) begin n_fail++; $display("FAIL cap_ctx: got %0d expected %0d", context_id, exp_ctx); end
  endtask

  task automatic test_backpressure();
    int es, el, os, ol;
    push_decode(0, MERGE_QUIET, 6);
    run_decode(0, 0, 5, 0);
    exp_ctx = (exp_ctx + 1) % NUM_CONTEXTS;
    n_checks++; if (timed_out || obs_st.size() != exp_st.size()) begin n_fail++; $display("FAIL bp_runs: got %0d runs (timeout %0b) expected %0d", obs_st.size(), timed_out, exp_st.size()); end
    while (exp_st.size() > 0) begin
      es = exp_st.pop_front(); el = exp_len.pop_front(); os = -1; ol = -1;
      if (obs_st.size() > 0) begin os = obs_st.pop_front(); ol = obs_len.pop_front(); end
      n_checks++; if (os !== es || ol !== el) begin n_fail++; $display("FAIL bp_run: got stage %0d x%0d expected stage %0d x%0d", os, ol, es, el); end
    end
    n_checks++; if (ov_cycles !== 6) begin n_fail++; $display("FAIL bp_valid_hold: got %0d cycles expected 6", ov_cycles); end
    n_checks++; if (int'(context_id) !== exp_ctx) begin n_fail++; $display("FAIL bp_ctx: got %0d expected %0d", context_id, exp_ctx); end
    run_decode(0, 0, 0, 0);
    exp_ctx = (exp_ctx + 1) % NUM_CONTEXTS;
    n_checks++; if (timed_out || int'(context_id) !== exp_ctx) begin n_fail++; $display("FAIL ctx_wrap: got %0d (timeout %0b) expected %0d", context_id, timed_out, exp_ctx); end
  endtask

  task automatic test_reset_mid_merge();
    int cyc = 0;
    odd = 16'hFFFF; busy = '0; output_ready = 0;
    @(negedge clk); input_valid = 1;
    @(negedge clk); input_valid = 0;
    while (!(int'(global_stage) == S_MERGE && iteration_count == 4'd1) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++; if (cyc >= 100) begin n_fail++; $display("FAIL midreset_reach_merge: got %0d cycles expected < 100", cyc); end
    reset = 1;
    #1;
    n_checks++; if (int'(global_stage) !== S_IDLE) begin n_fail++; $display("FAIL midreset_stage: got %0d expected %0d", global_stage, S_IDLE); end
    n_checks++; if (output_valid !== 1'b0 || input_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_handshake: got ov=%b ir=%b expected 0/0", output_valid, input_ready); end
    n_checks++; if (int'(context_id) !== exp_ctx || iteration_count !== 4'd0) begin n_fail++; $display("FAIL midreset_ctx_iter: got %0d/%0d expected %0d/0", context_id, iteration_count, exp_ctx); end
    @(negedge clk); reset = 0; odd = '0;
    #1;
    n_checks++; if (input_ready !== 1'b1 || int'(global_stage) !== S_IDLE) begin n_fail++; $display("FAIL midreset_release: got ir=%b stage=%0d expected 1/%0d", input_ready, global_stage, S_IDLE); end
    @(negedge clk);
    n_checks++; if (int'(global_stage) !== S_IDLE || int'(context_id) !== exp_ctx) begin n_fail++; $display("FAIL midreset_no_write: got stage=%0d ctx=%0d expected %0d/%0d", global_stage, context_id, S_IDLE, exp_ctx); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 2; k++) begin
      run_decode(1, 0, 0, 0);
      exp_ctx = (exp_ctx + 1) % NUM_CONTEXTS;
      n_checks++; if (timed_out || iteration_count !== 4'd1 || int'(context_id) !== exp_ctx) begin n_fail++; $display("FAIL b2b_decode%0d: got iter=%0d ctx=%0d (timeout %0b) expected 1/%0d", k, iteration_count, context_id, timed_out, exp_ctx); end
    end
  endtask

  initial begin
    reset = 1; input_valid = 0; busy = '0; odd = '0; output_ready = 0; exp_ctx = 0;
    test_reset();
    test_no_odd();
    test_two_rounds();
    test_busy_glitch();
    test_iter_cap();
    test_backpressure();
    test_reset_mid_merge();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
